ds_scoreboard: RTL



---
 rtl/ds_sb_pkg.sv | 24 ++
 rtl/ds_scoreboard_if.sv | 60 ++++++
 rtl/ds_fwd_mux.sv | 49 ++++
 rtl/ds_scoreboard.sv | 109 ++++++++++
 4 files changed

// File: rtl/ds_sb_pkg.sv
// ds_sb_pkg: shared constants and helpers for the decode-stage operand-hazard
// unit (ds_scoreboard and its operand forwarding mux).
//   AW                  register address width (log2 of the register count)
//   STG_EXE/MEM/WB      forwarding stage indices, EXE has the highest priority
//   *_D                 default values for the block parameters
//   cnt_width()         width needed to hold a count of 0..max_val
package ds_sb_pkg;

   localparam int AW         = 5;
   localparam int XLEN_D     = 32;
   localparam int NREG_D     = 32;
   localparam int NSTG_D     = 3;
   localparam int MAX_LONG_D = 4;
   localparam int SCW_D      = 32;

   localparam int STG_EXE = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ds_scoreboard_if.sv
// ds_scoreboard_if: bundles the decode, forwarding, long-latency completion
// and status signals of the operand-hazard unit.
//   master : pipeline side, drives decode/forward/completion, reads results
//   slave  : ds_scoreboard side
interface ds_scoreboard_if
   import ds_sb_pkg::*;
#(
   parameter int XLEN     = XLEN_D,
   parameter int NREG     = NREG_D,
   parameter int NSTG     = NSTG_D,
   parameter int MAX_LONG = MAX_LONG_D,
   parameter int SCW      = SCW_D
);
   localparam int CW = cnt_width(MAX_LONG);

   logic                 ds_valid;
   logic [AW-1:0]        ds_raddr1;
   logic [AW-1:0]        ds_raddr2;
   logic                 ds_need_r1;
   logic                 ds_need_r2;
   logic [XLEN-1:0]      rf_rdata1;
   logic [XLEN-1:0]      rf_rdata2;
   logic                 ds_issue;
   logic                 ds_rf_we;
   logic [AW-1:0]        ds_rf_waddr;
   logic                 ds_long_lat;
   logic                 flush;
   logic [NSTG-1:0]      fwd_we;
   logic [NSTG*AW-1:0]   fwd_waddr;
   logic [NSTG*XLEN-1:0] fwd_wdata;
   logic [NSTG-1:0]      fwd_rdy;
   logic                 lat_done;
   logic [AW-1:0]        lat_waddr;
   logic [XLEN-1:0]      rj_value;
   logic [XLEN-1:0]      rkd_value;
   logic                 ds_stall;
   logic [NREG-1:0]      busy_vec;
   logic [CW-1:0]        long_cnt;
   logic [SCW-1:0]       stall_cycles;
   logic                 sb_err;

   modport master (
      output ds_valid, ds_raddr1, ds_raddr2, ds_need_r1, ds_need_r2,
             rf_rdata1, rf_rdata2, ds_issue, ds_rf_we, ds_rf_waddr,
             ds_long_lat, flush, fwd_we, fwd_waddr, fwd_wdata, fwd_rdy,
             lat_done, lat_waddr,
      input  rj_value, rkd_value, ds_stall, busy_vec, long_cnt,
             stall_cycles, sb_err
   );

   modport slave (
      input  ds_valid, ds_raddr1, ds_raddr2, ds_need_r1, ds_need_r2,
             rf_rdata1, rf_rdata2, ds_issue, ds_rf_we, ds_rf_waddr,
             ds_long_lat, flush, fwd_we, fwd_waddr, fwd_wdata, fwd_rdy,
             lat_done, lat_waddr,
      output rj_value, rkd_value, ds_stall, busy_vec, long_cnt,
             stall_cycles, sb_err
   );

endinterface

// File: rtl/ds_fwd_mux.sv
// ds_fwd_mux: operand bypass for one source register.
//   addr_i/need_i     source address and whether the instruction uses it
//   rf_rdata_i        register file data (used when no stage hits)
//   fwd_we_i/waddr_i/wdata_i/rdy_i  per-stage forwarding bus
//   value_o           forwarded operand
//   hazard_o          the selected stage's result is not ready yet
module ds_fwd_mux
   import ds_sb_pkg::*;
#(
   parameter int XLEN = XLEN_D,
   parameter int NSTG = NSTG_D
)(
   input  logic [AW-1:0]        addr_i,
   input  logic                 need_i,
   input  logic [XLEN-1:0]      rf_rdata_i,
   input  logic [NSTG-1:0]      fwd_we_i,
   input  logic [NSTG*AW-1:0]   fwd_waddr_i,
   input  logic [NSTG*XLEN-1:0] fwd_wdata_i,
   input  logic [NSTG-1:0]      fwd_rdy_i,
   output logic [XLEN-1:0]      value_o,
   output logic                 hazard_o
);

   logic [XLEN-1:0] value_s;
   logic            hit_s;
   logic            rdy_s;

   // Priority select: scan from the oldest stage to the youngest so the
   // youngest hitting stage is the last one written and therefore wins.
   always_comb begin
      value_s = rf_rdata_i;
      hit_s   = 1'b0;
      rdy_s   = 1'b1;
      for (int i = NSTG - 1; i >= 0; i--) begin
         if (fwd_we_i[i] && (fwd_waddr_i[i*AW +: AW] == addr_i) &&
             (addr_i != {AW{1'b0}})) begin
            value_s = fwd_wdata_i[i*XLEN +: XLEN];
            hit_s   = 1'b1;
            rdy_s   = fwd_rdy_i[i];
         end else begin
            hit_s   = hit_s;
         end
      end
   end

   assign value_o  = value_s;
   assign hazard_o = need_i & hit_s & ~rdy_s;

endmodule

// File: rtl/ds_scoreboard.sv
// ds_scoreboard: decode-stage operand hazard unit. Forwards rj/rkd from the
// downstream stages, tracks long-latency destinations in a busy-bit
// scoreboard, and raises a single decode stall.
//   clk, resetn  clock, asynchronous active-low reset
//   sb           ds_scoreboard_if.slave: decode request, forwarding bus,
//                long-latency completion, forwarded operands, stall, status
module ds_scoreboard
   import ds_sb_pkg::*;
#(
   parameter int XLEN     = XLEN_D,
   parameter int NREG     = NREG_D,
   parameter int NSTG     = NSTG_D,
   parameter int MAX_LONG = MAX_LONG_D,
   parameter int SCW      = SCW_D
)(
   input  logic           clk,
   input  logic           resetn,
   ds_scoreboard_if.slave sb
);

   localparam int            CW      = cnt_width(MAX_LONG);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LONG);

   logic [NREG-1:0] busy_q, busy_d, set_mask_s, clr_mask_s;
   logic [CW-1:0]   long_cnt_q, long_cnt_d;
   logic [SCW-1:0]  stall_cycles_q, stall_cycles_d;
   logic            sb_err_q, sb_err_d;
   logic            haz1_s, haz2_s, raw1_s, raw2_s, wbusy_s, cap_s;
   logic            stall_s, set_s, inc_s, dec_s, underflow_s;

   ds_fwd_mux #(.XLEN(XLEN), .NSTG(NSTG)) u_fwd_rj (
      .addr_i(sb.ds_raddr1), .need_i(sb.ds_need_r1), .rf_rdata_i(sb.rf_rdata1),
      .fwd_we_i(sb.fwd_we), .fwd_waddr_i(sb.fwd_waddr),
      .fwd_wdata_i(sb.fwd_wdata), .fwd_rdy_i(sb.fwd_rdy),
      .value_o(sb.rj_value), .hazard_o(haz1_s)
   );

   ds_fwd_mux #(.XLEN(XLEN), .NSTG(NSTG)) u_fwd_rkd (
      .addr_i(sb.ds_raddr2), .need_i(sb.ds_need_r2), .rf_rdata_i(sb.rf_rdata2),
      .fwd_we_i(sb.fwd_we), .fwd_waddr_i(sb.fwd_waddr),
      .fwd_wdata_i(sb.fwd_wdata), .fwd_rdy_i(sb.fwd_rdy),
      .value_o(sb.rkd_value), .hazard_o(haz2_s)
   );

   // A busy source is fine in the cycle its long op completes: the result
   // is on a forwarding stage at that moment.
   assign raw1_s = sb.ds_need_r1 & busy_q[sb.ds_raddr1] &
                   (sb.ds_raddr1 != {AW{1'b0}}) &
                   ~(sb.lat_done & (sb.lat_waddr == sb.ds_raddr1));
   assign raw2_s = sb.ds_need_r2 & busy_q[sb.ds_raddr2] &
                   (sb.ds_raddr2 != {AW{1'b0}}) &
                   ~(sb.lat_done & (sb.lat_waddr == sb.ds_raddr2));
   // Writing a busy destination stalls both long (WAW) and short ops (a later
   // long completion would otherwise overwrite the short result).
   assign wbusy_s = sb.ds_rf_we & busy_q[sb.ds_rf_waddr];
   assign cap_s   = sb.ds_long_lat & (long_cnt_q == CNT_MAX);
   assign stall_s = sb.ds_valid &
                    (haz1_s | haz2_s | raw1_s | raw2_s | wbusy_s | cap_s);

   assign set_s = sb.ds_issue & ~sb.flush & ~stall_s & sb.ds_long_lat &
                  sb.ds_rf_we & (sb.ds_rf_waddr != {AW{1'b0}});
   assign inc_s = sb.ds_issue & sb.ds_long_lat;
   assign dec_s = sb.lat_done;
   assign underflow_s = dec_s & ~inc_s & (long_cnt_q == {CW{1'b0}});

   assign clr_mask_s = {{(NREG-1){1'b0}}, dec_s} << sb.lat_waddr;
   assign set_mask_s = {{(NREG-1){1'b0}}, set_s} << sb.ds_rf_waddr;
   assign busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;

   // Next-state for the in-flight counter, error flag and stall counter.
   always_comb begin
      long_cnt_d = long_cnt_q;
      case ({inc_s, dec_s})
         2'b10:   long_cnt_d = (long_cnt_q == CNT_MAX) ? long_cnt_q
                                                       : long_cnt_q + 1'b1;
         2'b01:   long_cnt_d = underflow_s ? long_cnt_q : long_cnt_q - 1'b1;
         default: long_cnt_d = long_cnt_q;
      endcase
      sb_err_d = sb_err_q | underflow_s |
                 (dec_s & ~busy_q[sb.lat_waddr] & (sb.lat_waddr != {AW{1'b0}}));
      if (stall_s && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
   end

   // State registers, cleared asynchronously by resetn.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q         <= {NREG{1'b0}};
         long_cnt_q     <= {CW{1'b0}};
         stall_cycles_q <= {SCW{1'b0}};
         sb_err_q       <= 1'b0;
      end else begin
         busy_q         <= busy_d;
         long_cnt_q     <= long_cnt_d;
         stall_cycles_q <= stall_cycles_d;
         sb_err_q       <= sb_err_d;
      end
   end

   assign sb.ds_stall     = stall_s;
   assign sb.busy_vec     = busy_q;
   assign sb.long_cnt     = long_cnt_q;
   assign sb.stall_cycles = stall_cycles_q;
   assign sb.sb_err       = sb_err_q;

endmodule
